// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file write arbiter.
// The default geometry matches the 64-entry, 64-bit register file.
package regfile_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_COUNT  = 64;
  localparam int DATA_W     = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus (valid/ready/addr/data) plus the registered
// write port towards the register file.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [(2**ADDR_W)-1:0]    wr_onehot;
  logic [DATA_W-1:0]         wr_data;
  logic                      init_done;

  // Requesters and the register file together form the master side.
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_onehot,
    input  wr_data,
    input  init_done
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output wr_en,
    output wr_addr,
    output wr_onehot,
    output wr_data,
    output init_done
  );

endinterface

// File: rtl/regfile_write_arbiter_onehot_decoder.sv
// Binary address to one-hot write-enable decoder shared by the clear
// sequencer and the arbitration path.
module onehot_decoder #(
  parameter int ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [(2**ADDR_W)-1:0] o_onehot
);

  always_comb begin
    o_onehot         = '0;
    o_onehot[i_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// writeback requesters, with a full-file zeroing sequence after reset.
module regfile_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W       = regfile_pkg::DATA_W,
  parameter bit PROTECT_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_clear,
  regfile_write_arbiter_if.slave  bus
);

  import regfile_pkg::*;

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ENTRIES = 2**ADDR_W;

  state_e               r_state;
  state_e               w_stateNext;
  logic [ADDR_W-1:0]    r_clrCnt;
  logic [ADDR_W-1:0]    w_clrCntNext;
  logic [PTR_W-1:0]     r_rrPtr;
  logic [PTR_W-1:0]     w_rrPtrNext;
  logic                 r_wrEn;
  logic                 w_wrEnNext;
  logic [ADDR_W-1:0]    r_wrAddr;
  logic [ADDR_W-1:0]    w_wrAddrNext;
  logic [ENTRIES-1:0]   r_wrOnehot;
  logic [ENTRIES-1:0]   w_wrOnehotNext;
  logic [DATA_W-1:0]    r_wrData;
  logic [DATA_W-1:0]    w_wrDataNext;
  logic                 r_initDone;
  logic                 w_initDoneNext;

  logic                 w_found;
  logic [PTR_W-1:0]     w_grant;
  logic [PTR_W-1:0]     w_grantPlusOne;
  logic [ADDR_W-1:0]    w_selAddr;
  logic [DATA_W-1:0]    w_selData;
  logic [ADDR_W-1:0]    w_decAddr;
  logic [ENTRIES-1:0]   w_decOnehot;
  logic                 w_zeroBlocked;
  logic [NUM_REQ-1:0]   w_ready;

  // Scan the requester list twice over so the search starting at r_rrPtr
  // wraps naturally; positions below the pointer are skipped.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < 2*NUM_REQ; k++) begin
      if (!w_found && (k >= int'(r_rrPtr)) && bus.req_valid[k % NUM_REQ]) begin
        w_found = 1'b1;
        w_grant = PTR_W'(k % NUM_REQ);
      end
    end
  end

  assign w_selAddr      = bus.req_addr[int'(w_grant)*ADDR_W +: ADDR_W];
  assign w_selData      = bus.req_data[int'(w_grant)*DATA_W +: DATA_W];
  assign w_grantPlusOne = (int'(w_grant) == NUM_REQ-1) ? '0 : w_grant + 1'b1;
  assign w_zeroBlocked  = PROTECT_ZERO && (w_selAddr == '0);
  assign w_decAddr      = (r_state == CLEAR) ? r_clrCnt : w_selAddr;

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_decoder (
    .i_addr   (w_decAddr),
    .o_onehot (w_decOnehot)
  );

  always_comb begin
    w_stateNext    = r_state;
    w_clrCntNext   = r_clrCnt;
    w_rrPtrNext    = r_rrPtr;
    w_wrEnNext     = 1'b0;
    w_wrAddrNext   = r_wrAddr;
    w_wrOnehotNext = '0;
    w_wrDataNext   = r_wrData;
    w_initDoneNext = r_initDone;
    w_ready        = '0;

    case (r_state)
      CLEAR: begin
        w_wrEnNext     = 1'b1;
        w_wrAddrNext   = r_clrCnt;
        w_wrOnehotNext = w_decOnehot;
        w_wrDataNext   = '0;
        w_clrCntNext   = r_clrCnt + 1'b1;
        if (r_clrCnt == '1) begin
          w_stateNext    = ARB;
          w_initDoneNext = 1'b1;
        end
      end

      ARB: begin
        // A clear request pre-empts every requester in the same cycle.
        if (start_clear) begin
          w_stateNext    = CLEAR;
          w_clrCntNext   = '0;
          w_initDoneNext = 1'b0;
        end else if (w_found) begin
          w_ready[w_grant] = 1'b1;
          w_rrPtrNext      = w_grantPlusOne;
          w_wrAddrNext     = w_selAddr;
          w_wrDataNext     = w_selData;
          if (!w_zeroBlocked) begin
            w_wrEnNext     = 1'b1;
            w_wrOnehotNext = w_decOnehot;
          end
        end
      end

      default: begin
        w_stateNext = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_clrCnt   <= '0;
      r_rrPtr    <= '0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrOnehot <= '0;
      r_wrData   <= '0;
      r_initDone <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_clrCnt   <= w_clrCntNext;
      r_rrPtr    <= w_rrPtrNext;
      r_wrEn     <= w_wrEnNext;
      r_wrAddr   <= w_wrAddrNext;
      r_wrOnehot <= w_wrOnehotNext;
      r_wrData   <= w_wrDataNext;
      r_initDone <= w_initDoneNext;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.wr_en     = r_wrEn;
  assign bus.wr_addr   = r_wrAddr;
  assign bus.wr_onehot = r_wrOnehot;
  assign bus.wr_data   = r_wrData;
  assign bus.init_done = r_initDone;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a
// behavioural model of the clear sequence and round-robin arbitration.
module tb_regfile_write_arbiter;

  localparam int N       = 4;
  localparam int AW      = 6;
  localparam int DW      = 64;
  localparam int ENTRIES = 64;

  logic clk = 1'b0;
  logic reset;
  logic startClear;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_write_arbiter #(
    .NUM_REQ      (N),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .PROTECT_ZERO (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_clear (startClear),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  logic          reqV [N];
  logic [AW-1:0] reqA [N];
  logic [DW-1:0] reqD [N];

  // Model: clear progress, round-robin pointer and expected write port.
  bit            mClear;
  int            mCnt;
  int            mPtr;
  bit            mInit;
  int            mGrant;
  bit            mKnown;
  logic          mEn;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  logic [63:0]   mOnehot;
  logic [N-1:0]  mReady;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sc);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = reqV[i];
      bus.req_addr[i*AW +: AW]  = reqA[i];
      bus.req_data[i*DW +: DW]  = reqD[i];
    end
    startClear = sc;
  endtask

  task automatic modelReset();
    mClear  = 1'b1;
    mCnt    = 0;
    mPtr    = 0;
    mInit   = 1'b0;
    mKnown  = 1'b1;
    mEn     = 1'b0;
    mAddr   = '0;
    mData   = '0;
    mOnehot = '0;
    mReady  = '0;
  endtask

  task automatic modelStep();
    mReady = '0;
    mGrant = -1;
    if (mClear) begin
      mEn     = 1'b1;
      mAddr   = AW'(mCnt);
      mData   = '0;
      mOnehot = 64'd1 << mCnt;
      mKnown  = 1'b1;
      mCnt++;
      if (mCnt == ENTRIES) begin
        mClear = 1'b0;
        mInit  = 1'b1;
      end
    end else if (startClear) begin
      mClear  = 1'b1;
      mCnt    = 0;
      mInit   = 1'b0;
      mEn     = 1'b0;
      mOnehot = '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        int c;
        c = (mPtr + j) % N;
        if (mGrant < 0 && reqV[c]) mGrant = c;
      end
      if (mGrant >= 0) begin
        mReady[mGrant] = 1'b1;
        mPtr = (mGrant + 1) % N;
        if (reqA[mGrant] == 0) begin
          mEn     = 1'b0;
          mOnehot = '0;
          mKnown  = 1'b0;
        end else begin
          mEn     = 1'b1;
          mAddr   = reqA[mGrant];
          mData   = reqD[mGrant];
          mOnehot = 64'd1 << reqA[mGrant];
          mKnown  = 1'b1;
        end
      end else begin
        mEn     = 1'b0;
        mOnehot = '0;
      end
    end
  endtask

  // One clock cycle: drive, check ready mid-cycle, check registers after the edge.
  task automatic cycle(input logic sc, input string tag);
    applyStimulus(sc);
    #2;
    modelStep();
    checkOutput({tag, ".req_ready"}, 64'(bus.req_ready), 64'(mReady));
    @(posedge clk);
    #1;
    checkOutput({tag, ".wr_en"}, 64'(bus.wr_en), 64'(mEn));
    checkOutput({tag, ".wr_onehot"}, bus.wr_onehot, mOnehot);
    checkOutput({tag, ".init_done"}, 64'(bus.init_done), 64'(mInit));
    if (mKnown) begin
      checkOutput({tag, ".wr_addr"}, 64'(bus.wr_addr), 64'(mAddr));
      checkOutput({tag, ".wr_data"}, bus.wr_data, mData);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".wr_en"}, 64'(bus.wr_en), 64'd0);
    checkOutput({tag, ".wr_onehot"}, bus.wr_onehot, 64'd0);
    checkOutput({tag, ".wr_addr"}, 64'(bus.wr_addr), 64'd0);
    checkOutput({tag, ".wr_data"}, bus.wr_data, 64'd0);
    checkOutput({tag, ".init_done"}, 64'(bus.init_done), 64'd0);
    checkOutput({tag, ".req_ready"}, 64'(bus.req_ready), 64'd0);
  endtask

  task automatic newRequest(input int i);
    reqV[i] = 1'($urandom_range(0, 1));
    reqA[i] = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, 63));
    reqD[i] = {$urandom, $urandom};
  endtask

  task automatic setReq(input int i, input logic v, input int a, input logic [DW-1:0] d);
    reqV[i] = v;
    reqA[i] = AW'(a);
    reqD[i] = d;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b1;
    startClear = 1'b0;
    for (int i = 0; i < N; i++) setReq(i, 1'b0, 0, '0);
    applyStimulus(1'b0);
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkResetOutputs("reset");
    reset = 1'b0;

    // Clear sequence with noisy requests and a start_clear that must be ignored.
    for (int n = 0; n < ENTRIES; n++) begin
      for (int i = 0; i < N; i++) newRequest(i);
      cycle((n == 10) ? 1'b1 : 1'b0, "clear");
    end

    // All four requesters valid: grants 0,1,2,3,0.
    setReq(0, 1'b1, 5,  64'hA0);
    setReq(1, 1'b1, 10, 64'hA1);
    setReq(2, 1'b1, 15, 64'hA2);
    setReq(3, 1'b1, 20, 64'hA3);
    for (int n = 0; n < 5; n++) cycle(1'b0, "rr4");

    // Lone requester wins back-to-back.
    for (int i = 0; i < N; i++) setReq(i, 1'b0, 0, '0);
    setReq(2, 1'b1, 63, 64'hDEAD);
    for (int n = 0; n < 3; n++) cycle(1'b0, "solo");

    // Write to address 0 is handshaken but suppressed; pointer still moves to 2.
    for (int i = 0; i < N; i++) setReq(i, 1'b0, 0, '0);
    setReq(1, 1'b1, 0, 64'h1234);
    cycle(1'b0, "zero");
    setReq(0, 1'b1, 3, 64'hB0);
    setReq(1, 1'b1, 7, 64'hB1);
    setReq(2, 1'b1, 9, 64'hB2);
    setReq(3, 1'b1, 11, 64'hB3);
    cycle(1'b0, "afterzero");

    // start_clear with pending requests: clear replays, pointer survives.
    for (int i = 0; i < N; i++) setReq(i, 1'b0, 0, '0);
    setReq(0, 1'b1, 33, 64'hC0);
    setReq(1, 1'b1, 44, 64'hC1);
    cycle(1'b1, "startclr");
    for (int n = 0; n < ENTRIES; n++) cycle(1'b0, "replay");
    for (int n = 0; n < 3; n++) cycle(1'b0, "resume");

    // Randomized traffic; requesters hold their request until granted.
    for (int i = 0; i < N; i++) newRequest(i);
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, "rand");
      if (mGrant >= 0) newRequest(mGrant);
      for (int i = 0; i < N; i++) begin
        if (!reqV[i] && $urandom_range(0, 2) == 0) newRequest(i);
      end
    end

    // Reset in the middle of a clear sequence.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    for (int n = 0; n < 30; n++) cycle(1'b0, "preclr");
    reset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    for (int n = 0; n < ENTRIES; n++) cycle(1'b0, "reclear");
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 8 + i, DW'(64'hE0 + i));
    for (int n = 0; n < 4; n++) cycle(1'b0, "postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single 6-to-64 write-address decode path of the 64-entry register file between NUM_REQ writeback requesters (ALU, load unit, etc.) using round-robin arbitration with a valid/ready handshake. After reset, and on request, it sequences the decoder through all 64 addresses to zero the register file before normal arbitration starts. All outputs to the register file are registered: the winning address, its one-hot enable and the write data.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
ADDR_W, 6, register address width; 2**ADDR_W entries
DATA_W, 64, write data width
PROTECT_ZERO, 1, 1 = writes to address 0 are accepted but suppressed (hard-wired zero register)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start_clear  in  1  pulse; restart the 64-entry zeroing sequence
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant; transfer when valid & ready
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
wr_en  out  1  registered write strobe to register file
wr_addr  out  ADDR_W  registered write address
wr_onehot  out  2**ADDR_W  registered decoded enable; all-zero when wr_en=0
wr_data  out  DATA_W  registered write data
init_done  out  1  high once a clear sequence has completed

Behaviour:
- Reset (async, immediate): state=CLEAR, clr_cnt=0, rr_ptr=0, wr_en=0, wr_addr=0, wr_onehot=0, wr_data=0, init_done=0; req_ready=0 (combinational, follows state).
- States: CLEAR, ARB.
- CLEAR: each cycle registers wr_en=1, wr_addr=clr_cnt, wr_onehot=1<<clr_cnt, wr_data=0; clr_cnt increments. The cycle issuing clr_cnt=63 moves to ARB and sets init_done=1. Exactly 64 consecutive strobes, addresses 0..63 in order; address 0 is written even when PROTECT_ZERO=1. req_ready is all zeros throughout. start_clear is ignored in CLEAR.
- ARB: grant index g is the first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready[g]=1 combinationally and all other bits are 0. At most one ready bit is high; none when no valid.
- Transfer (valid & ready): on the next edge wr_addr=req_addr[g], wr_data=req_data[g], wr_en=1, wr_onehot=1<<req_addr[g]. Latency is 1 cycle. rr_ptr <= (g+1) mod NUM_REQ.
- No transfer: wr_en=0 and wr_onehot=0 next cycle. wr_addr and wr_data hold their values. rr_ptr is unchanged.
- PROTECT_ZERO=1 and req_addr[g]=0: the handshake completes and rr_ptr advances, but next-cycle wr_en=0 and wr_onehot=0.
- Requesters hold valid, addr and data stable until ready. A single requester may win on back-to-back cycles when it is the only valid one.
- start_clear=1 in ARB: req_ready forced to 0 that cycle (clear wins over any request). Next state=CLEAR, clr_cnt=0, init_done=0, wr_en=0 next cycle. rr_ptr is preserved.
- Reset asserted mid-CLEAR or mid-transfer: outputs return to reset values immediately and any in-flight write is lost.
- Invariant: wr_onehot is zero or exactly one-hot, and is consistent with wr_addr whenever wr_en=1.

Decomposition:
- Shared package (regfile_pkg): REG_ADDR_W=6, REG_COUNT=64, DATA_W=64, state encodings CLEAR=1'b0, ARB=1'b1.
- Sub-module onehot_decoder: parametric ADDR_W to 2**ADDR_W combinational decoder, in -> one-hot. Instanced once and feeding the wr_onehot register; the mux selects clr_cnt or req_addr[g] ahead of it.
- Round-robin search stays inline as a for-loop over 2*NUM_REQ positions.

Test Plan:
- Reset release, no requests -> 64 cycles of wr_en=1, wr_addr 0..63, wr_onehot=1<<n, wr_data=0; init_done=1 after the cycle with addr 63; req_ready=0 throughout.
- After init, req_valid=4'b1111 held, addrs 5,10,15,20, data A0..A3 -> grants 0,1,2,3,0 on consecutive cycles; wr_addr 5,10,15,20,5, each one cycle after its ready.
- Only requester 2 valid, addr 63, data 64'hDEAD -> req_ready=4'b0100 every cycle; wr_onehot bit 63 set, wr_data=DEAD every following cycle.
- Requester 1 writes addr 0 with PROTECT_ZERO=1 -> ready asserted, next cycle wr_en=0, wr_onehot=0; rr_ptr advances to 2.
- start_clear pulse while req_valid=4'b0011 -> req_ready=0 that cycle, init_done drops, 64-entry clear replays, then arbitration resumes starting at the preserved rr_ptr.
- reset asserted at clear count 30 -> outputs zero asynchronously; after release the clear restarts at address 0.
